// File: rtl/memory_bira.sv
// Built-in redundancy analysis: merges BIST fault strobes into a table of unique failing rows,
// one spare per entry, then remaps functional addresses onto spares when the run is repairable.
module memory_bira #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SPARES = 4,
  localparam int unsigned IdxW = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
  localparam int unsigned CntW = $clog2(NUM_SPARES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bist_start,
  input  logic                  bist_done,
  input  logic                  fault_valid,
  input  logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic [DATA_WIDTH-1:0] fault_bits,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] func_addr,
  output logic                  remap_hit,
  output logic [IdxW-1:0]       remap_idx,
  output logic                  collecting,
  output logic                  repair_done,
  output logic                  repairable,
  output logic                  overflow,
  output logic [CntW-1:0]       spares_used,
  output logic [15:0]           fault_count,
  input  logic [IdxW-1:0]       rd_idx,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_bits
);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e state_q, state_d;

  logic [NUM_SPARES-1:0] valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [NUM_SPARES];
  logic [ADDR_WIDTH-1:0] addr_d [NUM_SPARES];
  logic [DATA_WIDTH-1:0] bits_q [NUM_SPARES];
  logic [DATA_WIDTH-1:0] bits_d [NUM_SPARES];
  logic [CntW-1:0]       used_q, used_d;
  logic [15:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  remap_hit_q, remap_hit_d;
  logic [IdxW-1:0]       remap_idx_q, remap_idx_d;

  logic                  accept;
  logic [NUM_SPARES-1:0] hit_vec;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else if (bist_start) begin
      state_d = StCollect;
    end else if (state_q == StCollect && bist_done) begin
      state_d = StDone;
    end
  end

  // FSM: outputs
  always_comb begin
    collecting  = (state_q == StCollect);
    repair_done = (state_q == StDone);
    repairable  = (state_q == StDone) && !ovf_q;
  end

  assign accept = (state_q == StCollect) && fault_valid && !clear && !bist_start;

  // Lookup against registered contents so a repeated new address merges on the next cycle.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_SPARES; i++) begin
      hit_vec[i] = valid_q[i] && (addr_q[i] == fault_addr);
    end
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    bits_d  = bits_q;
    used_d  = used_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear || bist_start) begin
      valid_d = '0;
      used_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      for (int i = 0; i < NUM_SPARES; i++) begin
        addr_d[i] = '0;
        bits_d[i] = '0;
      end
    end else if (accept) begin
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      if (|hit_vec) begin
        for (int i = 0; i < NUM_SPARES; i++) begin
          if (hit_vec[i]) bits_d[i] = bits_q[i] | fault_bits;
        end
      end else if (used_q < CntW'(NUM_SPARES)) begin
        for (int i = 0; i < NUM_SPARES; i++) begin
          if (CntW'(i) == used_q) begin
            valid_d[i] = 1'b1;
            addr_d[i]  = fault_addr;
            bits_d[i]  = fault_bits;
          end
        end
        used_d = used_q + CntW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    remap_hit_d = 1'b0;
    remap_idx_d = '0;
    if (repairable) begin
      for (int i = 0; i < NUM_SPARES; i++) begin
        if (valid_q[i] && addr_q[i] == func_addr) begin
          remap_hit_d = 1'b1;
          remap_idx_d = IdxW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      used_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      remap_hit_q <= 1'b0;
      remap_idx_q <= '0;
      for (int i = 0; i < NUM_SPARES; i++) begin
        addr_q[i] <= '0;
        bits_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      used_q      <= used_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      remap_hit_q <= remap_hit_d;
      remap_idx_q <= remap_idx_d;
      for (int i = 0; i < NUM_SPARES; i++) begin
        addr_q[i] <= addr_d[i];
        bits_q[i] <= bits_d[i];
      end
    end
  end

  // Unallocated entries are held at zero, so gating on valid yields the required zero read-back.
  always_comb begin
    rd_valid = 1'b0;
    rd_addr  = '0;
    rd_bits  = '0;
    for (int i = 0; i < NUM_SPARES; i++) begin
      if (IdxW'(i) == rd_idx && valid_q[i]) begin
        rd_valid = 1'b1;
        rd_addr  = addr_q[i];
        rd_bits  = bits_q[i];
      end
    end
  end

  assign remap_hit   = remap_hit_q;
  assign remap_idx   = remap_idx_q;
  assign overflow    = ovf_q;
  assign spares_used = used_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_memory_bira.sv
// Scenario bench for memory_bira: expected values are queued when stimulus is driven and popped
// when the DUT result is sampled half a cycle after the capturing edge.
module tb_memory_bira;

  logic        clk = 1'b0;
  logic        rst_n, bist_start, bist_done, fault_valid, clear;
  logic [7:0]  fault_addr, func_addr, rd_addr;
  logic [31:0] fault_bits, rd_bits;
  logic        remap_hit, collecting, repair_done, repairable, overflow, rd_valid;
  logic [1:0]  remap_idx, rd_idx;
  logic [2:0]  spares_used;
  logic [15:0] fault_count;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;

  always #5 clk = ~clk;

  memory_bira dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bist_start (bist_start),
    .bist_done  (bist_done),
    .fault_valid(fault_valid),
    .fault_addr (fault_addr),
    .fault_bits (fault_bits),
    .clear      (clear),
    .func_addr  (func_addr),
    .remap_hit  (remap_hit),
    .remap_idx  (remap_idx),
    .collecting (collecting),
    .repair_done(repair_done),
    .repairable (repairable),
    .overflow   (overflow),
    .spares_used(spares_used),
    .fault_count(fault_count),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_bits    (rd_bits)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
  endtask

  task automatic pulse_done();
    bist_done = 1'b1;
    tick();
    bist_done = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] a, input logic [31:0] b);
    fault_valid = 1'b1;
    fault_addr  = a;
    fault_bits  = b;
    tick();
    fault_valid = 1'b0;
  endtask

  // Drives func_addr, queues the expected {hit, idx}, and checks it after the capturing edge.
  task automatic test_remap(input string name, input logic [7:0] a, input logic hit,
                            input logic [1:0] idx);
    func_addr = a;
    exp_q.push_back({61'd0, hit, idx});
    tick();
    e = exp_q.pop_front();
    total++;
    if ({remap_hit, remap_idx} !== e[2:0]) begin
      bad++;
      $display("FAIL %s got hit=%0b idx=%0d want hit=%0b idx=%0d", name, remap_hit, remap_idx,
               e[2], e[1:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.push_back(64'd0);
    e = exp_q.pop_front();
    total++;
    if ({remap_hit, remap_idx, collecting, repair_done, repairable, overflow, spares_used,
         fault_count, rd_valid} !== e[27:0]) begin
      bad++;
      $display("FAIL reset_outputs got hit=%0b idx=%0d col=%0b done=%0b rep=%0b ovf=%0b used=%0d cnt=%0d rdv=%0b want all 0",
               remap_hit, remap_idx, collecting, repair_done, repairable, overflow,
               spares_used, fault_count, rd_valid);
    end
  endtask

  task automatic test_clean();
    pulse_start();
    total++;
    if (collecting !== 1'b1) begin
      bad++; $display("FAIL clean_collecting got=%0b want=1", collecting);
    end
    pulse_done();
    exp_q.push_back({58'd0, 1'b1, 1'b1, 1'b0, 3'd0});
    e = exp_q.pop_front();
    total++;
    if ({repair_done, repairable, collecting, spares_used} !== e[5:0]) begin
      bad++;
      $display("FAIL clean_done got done=%0b rep=%0b col=%0b used=%0d want 1 1 0 0",
               repair_done, repairable, collecting, spares_used);
    end
    total++;
    if (fault_count !== 16'd0) begin
      bad++; $display("FAIL clean_count got=%0d want=0", fault_count);
    end
    test_remap("clean_remap", 8'h64, 1'b0, 2'd0);
  endtask

  task automatic test_merge();
    logic [31:0] want_bits;
    pulse_start();
    want_bits = 32'h0000_FF00;
    strobe(8'h64, 32'h0000_FF00);
    want_bits = want_bits | 32'h0000_00F0;
    exp_q.push_back({8'h64, want_bits});
    strobe(8'h64, 32'h0000_00F0);
    e = exp_q.pop_front();
    rd_idx = 2'd0;
    #1;
    total++;
    if ({rd_valid, rd_addr, rd_bits} !== {1'b1, e[39:0]}) begin
      bad++;
      $display("FAIL merge_entry0 got v=%0b a=%h b=%h want v=1 a=%h b=%h", rd_valid, rd_addr,
               rd_bits, e[39:32], e[31:0]);
    end
    total++;
    if (spares_used !== 3'd1 || fault_count !== 16'd2) begin
      bad++;
      $display("FAIL merge_counts got used=%0d cnt=%0d want used=1 cnt=2", spares_used,
               fault_count);
    end
    rd_idx = 2'd1;
    #1;
    total++;
    if ({rd_valid, rd_addr, rd_bits} !== 41'd0) begin
      bad++;
      $display("FAIL merge_entry1 got v=%0b a=%h b=%h want all 0", rd_valid, rd_addr, rd_bits);
    end
    test_remap("merge_remap_collecting", 8'h64, 1'b0, 2'd0);
    pulse_done();
    test_remap("merge_remap_hit", 8'h64, 1'b1, 2'd0);
    test_remap("merge_remap_other", 8'h65, 1'b0, 2'd0);
  endtask

  task automatic test_overflow();
    logic [7:0] addrs [4];
    addrs = '{8'h10, 8'h20, 8'h30, 8'h40};
    pulse_start();
    foreach (addrs[i]) strobe(addrs[i], 32'h1 << i);
    total++;
    if (spares_used !== 3'd4 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_full got used=%0d ovf=%0b want used=4 ovf=0", spares_used, overflow);
    end
    strobe(8'h20, 32'h8000_0000);
    rd_idx = 2'd1;
    #1;
    total++;
    if (overflow !== 1'b0 || rd_bits !== 32'h8000_0002) begin
      bad++;
      $display("FAIL ovf_merge_when_full got ovf=%0b bits=%h want ovf=0 bits=80000002",
               overflow, rd_bits);
    end
    strobe(8'h50, 32'hFFFF_FFFF);
    total++;
    if (spares_used !== 3'd4 || overflow !== 1'b1 || fault_count !== 16'd6) begin
      bad++;
      $display("FAIL ovf_set got used=%0d ovf=%0b cnt=%0d want used=4 ovf=1 cnt=6", spares_used,
               overflow, fault_count);
    end
    rd_idx = 2'd3;
    #1;
    total++;
    if (rd_addr !== 8'h40) begin
      bad++; $display("FAIL ovf_entry3 got=%h want=40", rd_addr);
    end
    pulse_done();
    total++;
    if (repair_done !== 1'b1 || repairable !== 1'b0) begin
      bad++;
      $display("FAIL ovf_repairable got done=%0b rep=%0b want done=1 rep=0", repair_done,
               repairable);
    end
    test_remap("ovf_remap", 8'h10, 1'b0, 2'd0);
  endtask

  task automatic test_priority();
    bist_start = 1'b1;
    fault_valid = 1'b1;
    fault_addr = 8'h77;
    fault_bits = 32'h1;
    tick();
    bist_start = 1'b0;
    fault_valid = 1'b0;
    total++;
    if (fault_count !== 16'd0 || spares_used !== 3'd0) begin
      bad++;
      $display("FAIL prio_start_drop got cnt=%0d used=%0d want 0 0", fault_count, spares_used);
    end
    bist_done = 1'b1;
    strobe(8'h77, 32'h2);
    bist_done = 1'b0;
    total++;
    if (fault_count !== 16'd1 || repair_done !== 1'b1 || spares_used !== 3'd1) begin
      bad++;
      $display("FAIL prio_done_accept got cnt=%0d done=%0b used=%0d want 1 1 1", fault_count,
               repair_done, spares_used);
    end
    strobe(8'h78, 32'h4);
    total++;
    if (fault_count !== 16'd1) begin
      bad++; $display("FAIL prio_done_ignore got cnt=%0d want=1", fault_count);
    end
    test_remap("prio_remap", 8'h77, 1'b1, 2'd0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] addrs [3];
    addrs = '{8'h11, 8'h22, 8'h33};
    pulse_start();
    foreach (addrs[i]) strobe(addrs[i], 32'h10 << i);
    pulse_done();
    foreach (addrs[i]) test_remap("b2b_remap", addrs[i], 1'b1, 2'(i));
  endtask

  task automatic test_restart();
    pulse_start();
    total++;
    if (spares_used !== 3'd0 || collecting !== 1'b1 || repair_done !== 1'b0) begin
      bad++;
      $display("FAIL restart_state got used=%0d col=%0b done=%0b want 0 1 0", spares_used,
               collecting, repair_done);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      total++;
      if (rd_valid !== 1'b0 || rd_bits !== 32'd0) begin
        bad++;
        $display("FAIL restart_rd idx=%0d got v=%0b bits=%h want 0", i, rd_valid, rd_bits);
      end
    end
  endtask

  task automatic test_reset_mid();
    strobe(8'h01, 32'h1);
    strobe(8'h02, 32'h2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulse_done();
    total++;
    if ({collecting, repair_done, repairable, overflow, spares_used, fault_count} !== 23'd0) begin
      bad++;
      $display("FAIL reset_mid got col=%0b done=%0b rep=%0b ovf=%0b used=%0d cnt=%0d want 0",
               collecting, repair_done, repairable, overflow, spares_used, fault_count);
    end
  endtask

  task automatic test_clear();
    pulse_start();
    strobe(8'h05, 32'h5);
    clear = 1'b1;
    strobe(8'h06, 32'h6);
    clear = 1'b0;
    total++;
    if (collecting !== 1'b0 || spares_used !== 3'd0 || fault_count !== 16'd0) begin
      bad++;
      $display("FAIL clear got col=%0b used=%0d cnt=%0d want 0 0 0", collecting, spares_used,
               fault_count);
    end
  endtask

  initial begin
    rst_n = 1'b1; bist_start = 1'b0; bist_done = 1'b0; fault_valid = 1'b0; clear = 1'b0;
    fault_addr = '0; fault_bits = '0; func_addr = '0; rd_idx = '0;
    @(negedge clk);
    test_reset();
    test_clean();
    test_merge();
    test_overflow();
    test_priority();
    test_back_to_back();
    test_restart();
    test_reset_mid();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_bira.md
# memory_bira

Built-in redundancy analysis stage placed directly downstream of `memory_bist`. It consumes the per-mismatch fault strobes the BIST engine produces during a run and merges them into a small table of unique faulty word addresses. Each table entry is allocated one spare row. After the run it reports whether the memory is repairable and remaps functional addresses onto spare rows. It also exposes a read-back port so software or the test-bench can dump the fault map.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, memory word-address width (matches `memory_bist`).
- `DATA_WIDTH`, 32, memory word width.
- `NUM_SPARES`, 4, spare rows and table entries, 1..16.

Ports:
- `clk` in 1: single clock. All logic is posedge.
- `rst_n` in 1: **synchronous, active-low** reset.
- `bist_start` in 1: same pulse that launches `memory_bist`. Clears the table and opens a collect window.
- `bist_done` in 1: BIST completion pulse. Closes the collect window.
- `fault_valid` in 1: one-cycle strobe, one per detected mismatch.
- `fault_addr` in ADDR_WIDTH: failing address, qualified by `fault_valid`.
- `fault_bits` in DATA_WIDTH: failing-bit syndrome (expected XOR actual), qualified by `fault_valid`.
- `clear` in 1: discard table and return to IDLE.
- `func_addr` in ADDR_WIDTH: functional-path address to translate.
- `remap_hit` out 1: registered. `func_addr` is mapped to a spare.
- `remap_idx` out clog2(NUM_SPARES) (min 1): registered spare index for the hit.
- `collecting` out 1: high in COLLECT.
- `repair_done` out 1: high in DONE.
- `repairable` out 1: high in DONE when no overflow occurred.
- `overflow` out 1: sticky. A unique fault arrived with the table full.
- `spares_used` out clog2(NUM_SPARES+1): number of allocated entries.
- `fault_count` out 16: total accepted strobes, saturates at 16'hFFFF.
- `rd_idx` in clog2(NUM_SPARES): read-back entry select.
- `rd_valid`/`rd_addr`/`rd_bits` out 1/ADDR_WIDTH/DATA_WIDTH: combinational view of entry `rd_idx`.

## Operation
- Each table entry holds `valid`, `addr` and `bits`. Entries are allocated in index order 0,1,2,… and are never freed within a run.
- States and transitions:
  - IDLE → COLLECT on `bist_start`.
  - COLLECT → DONE on `bist_done`.
  - DONE → COLLECT on `bist_start`.
  - Any state → IDLE on `clear`.
- Entering COLLECT from either IDLE or DONE clears all entries, `overflow`, `spares_used` and `fault_count`. `clear` does the same.
- Priority within a cycle: `rst_n` low > `clear` > `bist_start` > `fault_valid`.
  - A strobe coincident with `bist_start` is dropped.
  - A strobe coincident with `clear` is dropped.
- `fault_valid` is accepted only in COLLECT. A strobe coincident with `bist_done` in COLLECT is accepted. Strobes in IDLE or DONE are ignored.
- Handling of an accepted strobe:
  - `fault_count` increments and saturates.
  - Lookup compares `fault_addr` against all valid entries in parallel.
  - On a hit, `bits |= fault_bits`. `spares_used` is unchanged.
  - On a miss with a free entry, entry[`spares_used`] is set to {1, `fault_addr`, `fault_bits`} and `spares_used` increments.
  - On a miss with the table full, `overflow` is set and the table is unchanged.
- `repairable` = (state == DONE) && !`overflow`. A zero-fault run is repairable with `spares_used` = 0.
- Remap is enabled only while `repairable`. When disabled, `remap_hit` = 0 and `remap_idx` = 0.
- The read-back port is valid in every state. Entries at or beyond `spares_used` read `rd_valid` = 0, `rd_addr` = 0, `rd_bits` = 0.

## Timing
- Reset values:
  - State = IDLE.
  - All entries invalid and zero.
  - `remap_hit`, `remap_idx`, `collecting`, `repair_done`, `repairable`, `overflow`, `spares_used`, `fault_count` = 0.
- A strobe sampled at edge N updates the table, `spares_used`, `fault_count` and `overflow` at N; they are visible after that edge. Back-to-back strobes every cycle are supported, including a repeat of the same new address on consecutive cycles, which must merge rather than double-allocate. The lookup therefore uses the current register contents.
- `bist_done` sampled at edge N: `repair_done` and `repairable` are high from N.
- `bist_start` sampled at edge N: `collecting` is high and all counters are zero from N.
- Remap latency is 1 cycle: `func_addr` at edge N yields `remap_hit`/`remap_idx` after N.
- Reset or `clear` mid-COLLECT: the whole table is lost immediately. A later `bist_done` without a new `bist_start` is ignored.

## Test plan
- **Clean run:** `bist_start`, no strobes, `bist_done` → `repair_done` = 1, `repairable` = 1, `spares_used` = 0, `fault_count` = 0. `func_addr` = 0x64 gives `remap_hit` = 0.
- **Merge:** strobes at addr 0x64 with bits 0x0000FF00, then addr 0x64 with bits 0x000000F0 on the next cycle → `spares_used` = 1, entry0 = {0x64, 0x0000FFF0}, `fault_count` = 2. After `bist_done`, `func_addr` = 0x64 gives `remap_hit` = 1 and `remap_idx` = 0 one cycle later.
- **Overflow:** unique addrs 0x10, 0x20, 0x30, 0x40, then 0x50 → `spares_used` = 4, `overflow` = 1. After `bist_done`, `repairable` = 0 and `func_addr` = 0x10 gives `remap_hit` = 0.
- **Priority:**
  - `fault_valid` on the same cycle as `bist_start` → `fault_count` = 0.
  - `fault_valid` on the same cycle as `bist_done` → accepted, `fault_count` = 1.
- **Reset mid-run:** 2 faults, then `rst_n` low for 1 cycle, then `bist_done` → state IDLE, all outputs 0, `repair_done` stays 0.
- **Restart:** DONE with 3 entries, then `bist_start` → `spares_used` = 0, `rd_valid` = 0 for all `rd_idx`, `collecting` = 1.
